riscv_mmio_uart: RTL

//  Memory-mapped I/O controller between the Riscv151 datapath and the UART rx/tx pair.

---
 rtl/riscv_mmio_uart_if.sv | 20 ++
 rtl/riscv_mmio_uart.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_uart_if.sv
// Load/store port between the Riscv151 datapath and its memory-mapped I/O block.
// The core drives the request side; the I/O block returns registered load data.
interface riscv_mmio_uart_if;
  logic [31:0] io_addr;
  logic        io_re;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [3:0]  io_wbe;
  logic [31:0] io_rdata;

  modport master (
    output io_addr, io_re, io_we, io_wdata, io_wbe,
    input  io_rdata
  );

  modport slave (
    input  io_addr, io_re, io_we, io_wdata, io_wbe,
    output io_rdata
  );
endinterface

// File: rtl/riscv_mmio_uart.sv
// MMIO controller for the Riscv151 core: UART RX/TX byte FIFOs, a sticky TX-drop
// flag, and free-running cycle / retired-instruction counters.
module riscv_mmio_uart #(
  parameter int          RX_DEPTH = 8,
  parameter int          TX_DEPTH = 8,
  parameter logic [31:0] IO_BASE  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_mmio_uart_if.slave     io,
  input  logic                 instr_retired,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_INSTRS = 8'h14;
  localparam logic [7:0] OFF_CNTRST = 8'h18;

  // ---------------------------------------------------------------- decode
  logic       in_window;
  logic [7:0] offset;
  logic       rd_rxdata;
  logic       wr_status_clr;
  logic       wr_txdata;
  logic       wr_cntrst;

  assign in_window     = (io.io_addr[31:28] == IO_BASE[31:28]);
  assign offset        = io.io_addr[7:0];
  assign rd_rxdata     = io.io_re && in_window && (offset == OFF_RXDATA);
  assign wr_status_clr = io.io_we && in_window && (offset == OFF_STATUS)
                         && io.io_wbe[0] && io.io_wdata[2];
  assign wr_txdata     = io.io_we && in_window && (offset == OFF_TXDATA) && io.io_wbe[0];
  assign wr_cntrst     = io.io_we && in_window && (offset == OFF_CNTRST);

  logic unused_bits;
  assign unused_bits = &{1'b0, io.io_addr[27:8], io.io_wdata[31:8], io.io_wbe[3:1]};

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_full;
  logic             rx_nonempty;
  logic             rx_push;
  logic             rx_pop;

  assign rx_full     = (rx_count == RX_FULL_CNT);
  assign rx_nonempty = (rx_count != '0);
  assign rx_ready    = !rx_full;
  assign rx_push     = rx_valid && !rx_full;
  // Pop is qualified by the registered occupancy, so a read on an empty FIFO
  // never consumes a byte arriving in the same cycle.
  assign rx_pop      = rd_rxdata && rx_nonempty;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW + 1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_drop_set;
  logic             tx_drop;

  assign tx_full     = (tx_count == TX_FULL_CNT);
  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rd_ptr];
  assign tx_pop      = tx_valid && tx_ready;
  // Fullness is the registered occupancy: a pop in the same cycle does not make room.
  assign tx_push     = wr_txdata && !tx_full;
  assign tx_drop_set = wr_txdata && tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= io.io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_drop   <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW + 1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW + 1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_drop_set) begin
        tx_drop <= 1'b1;
      end else if (wr_status_clr) begin
        tx_drop <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- counters
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  always_ff @(posedge clk) begin
    if (rst || wr_cntrst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (instr_retired) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] rd_value;
  logic [31:0] rdata_q;

  always_comb begin
    rd_value = '0;
    if (in_window) begin
      case (offset)
        OFF_STATUS: rd_value = {29'b0, tx_drop, rx_nonempty, !tx_full};
        OFF_RXDATA: rd_value = rx_nonempty ? {24'b0, rx_mem[rx_rd_ptr]} : 32'b0;
        OFF_CYCLES: rd_value = cycle_count;
        OFF_INSTRS: rd_value = instr_count;
        default:    rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= io.io_re ? rd_value : 32'b0;
    end
  end

  assign io.io_rdata = rdata_q;

endmodule
